// File: rtl/fmt_sink.sv
// Formatter-side packet sink: grants on buffer space, checks framing, commits good
// packets atomically to a FIFO and streams them out with channel id and last flag.
module fmt_sink #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned START_TO  = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fmt_req_i,
    input  logic [1:0]           fmt_chid_i,
    input  logic [5:0]           fmt_length_i,
    input  logic [31:0]          fmt_data_i,
    input  logic                 fmt_start_i,
    input  logic                 fmt_end_i,
    output logic                 fmt_grant_o,
    output logic                 out_vld_o,
    input  logic                 out_rdy_i,
    output logic [31:0]          out_data_o,
    output logic [1:0]           out_chid_o,
    output logic                 out_last_o,
    output logic [CNT_WIDTH-1:0] pkt_cnt0_o,
    output logic [CNT_WIDTH-1:0] pkt_cnt1_o,
    output logic [CNT_WIDTH-1:0] pkt_cnt2_o,
    output logic                 err_o,
    output logic [2:0]           err_code_o,
    input  logic                 err_clr_i
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = $clog2(START_TO) + 1;
    localparam int unsigned EW = 35;

    typedef enum logic [1:0] {IDLE, GRANT, WAIT_START, RECV} state_t;
    state_t state, state_nxt;

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] rd_word;
    logic [PW-1:0] rd_ptr, wr_ptr, cm_ptr, used, free;
    logic [1:0]    chid_q;
    logic [5:0]    len_q, last_idx, k_q, k_cur, k_nxt;
    logic          hdr_bad_q;
    logic [TW-1:0] to_cnt;
    logic          accept, wr_en, wr_last, commit, rollback, err_ev, rd_en;
    logic [2:0]    err_ev_code;

    assign used     = wr_ptr - rd_ptr;
    assign free     = PW'(DEPTH) - used;
    assign last_idx = len_q - 6'd1;
    assign k_cur    = (state == RECV) ? k_q : 6'd0;

    // Next state and per-word framing rules; a start in WAIT_START is word 0.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        wr_en       = 1'b0;
        wr_last     = 1'b0;
        commit      = 1'b0;
        rollback    = 1'b0;
        err_ev      = 1'b0;
        err_ev_code = 3'd0;
        k_nxt       = k_q;
        case (state)
            IDLE: begin
                if (fmt_req_i && (32'(free) >= 32'(fmt_length_i))) begin
                    accept    = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: state_nxt = WAIT_START;
            WAIT_START, RECV: begin
                if ((state == WAIT_START) && !fmt_start_i) begin
                    if (to_cnt == TW'(START_TO - 1)) begin
                        err_ev      = 1'b1;
                        err_ev_code = 3'd3;
                        state_nxt   = IDLE;
                    end
                end else begin
                    wr_en     = 1'b1;
                    state_nxt = RECV;
                    k_nxt     = k_cur + 6'd1;
                    if (fmt_end_i && (k_cur < last_idx)) begin
                        err_ev_code = 3'd1;
                    end else if (fmt_start_i && (k_cur != 6'd0)) begin
                        err_ev_code = 3'd4;
                    end else if ((k_cur == last_idx) && !fmt_end_i) begin
                        err_ev_code = 3'd2;
                    end else if ((k_cur == last_idx) && hdr_bad_q) begin
                        err_ev_code = 3'd5;
                    end else if (k_cur == last_idx) begin
                        wr_last   = 1'b1;
                        commit    = 1'b1;
                        state_nxt = IDLE;
                    end
                    if (err_ev_code != 3'd0) begin
                        err_ev    = 1'b1;
                        rollback  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Buffer storage is not reset; visibility is gated by the pointers.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {chid_q, wr_last, fmt_data_i};
    end

    assign rd_en = out_vld_o && out_rdy_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fmt_grant_o <= 1'b0;
            chid_q      <= 2'd0;
            len_q       <= 6'd0;
            hdr_bad_q   <= 1'b0;
            k_q         <= 6'd0;
            to_cnt      <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            cm_ptr      <= '0;
            pkt_cnt0_o  <= '0;
            pkt_cnt1_o  <= '0;
            pkt_cnt2_o  <= '0;
            err_o       <= 1'b0;
            err_code_o  <= 3'd0;
        end else begin
            fmt_grant_o <= accept;
            if (accept) begin
                chid_q    <= fmt_chid_i;
                len_q     <= fmt_length_i;
                hdr_bad_q <= (fmt_chid_i == 2'd3) || (fmt_length_i == 6'd0);
            end
            k_q <= k_nxt;
            if (state == GRANT)           to_cnt <= '0;
            else if (state == WAIT_START) to_cnt <= to_cnt + TW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            if (rollback)   wr_ptr <= cm_ptr;
            else if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (commit) begin
                cm_ptr <= wr_ptr + PW'(1);
                case (chid_q)
                    2'd0:    pkt_cnt0_o <= pkt_cnt0_o + CNT_WIDTH'(1);
                    2'd1:    pkt_cnt1_o <= pkt_cnt1_o + CNT_WIDTH'(1);
                    2'd2:    pkt_cnt2_o <= pkt_cnt2_o + CNT_WIDTH'(1);
                    default: ;
                endcase
            end
            // An error event in the same cycle outranks a clear.
            if (err_ev) begin
                err_o      <= 1'b1;
                err_code_o <= err_ev_code;
            end else if (err_clr_i) begin
                err_o      <= 1'b0;
                err_code_o <= 3'd0;
            end
        end
    end

    assign rd_word   = mem[rd_ptr[AW-1:0]];
    assign out_vld_o = (rd_ptr != cm_ptr);
    assign {out_chid_o, out_last_o, out_data_o} = out_vld_o ? rd_word : '0;

endmodule

// File: tb/tb_fmt_sink.sv
// Randomized bench for fmt_sink: transaction-level model of commit/error outcomes,
// an expected-word queue checked every cycle, and a few literal pinned values.
module tb_fmt_sink;
    localparam int unsigned DEPTH    = 64;
    localparam int unsigned START_TO = 4;
    localparam int unsigned CW       = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i, fmt_req_i, fmt_start_i, fmt_end_i, fmt_grant_o;
    logic [1:0] fmt_chid_i, out_chid_o;
    logic [5:0] fmt_length_i;
    logic [31:0] fmt_data_i, out_data_o;
    logic out_vld_o, out_rdy_i, out_last_o, err_o, err_clr_i;
    logic [CW-1:0] pkt_cnt0_o, pkt_cnt1_o, pkt_cnt2_o;
    logic [2:0] err_code_o;

    fmt_sink #(.DEPTH(DEPTH), .START_TO(START_TO), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .fmt_req_i(fmt_req_i), .fmt_chid_i(fmt_chid_i),
        .fmt_length_i(fmt_length_i), .fmt_data_i(fmt_data_i), .fmt_start_i(fmt_start_i),
        .fmt_end_i(fmt_end_i), .fmt_grant_o(fmt_grant_o), .out_vld_o(out_vld_o),
        .out_rdy_i(out_rdy_i), .out_data_o(out_data_o), .out_chid_o(out_chid_o),
        .out_last_o(out_last_o), .pkt_cnt0_o(pkt_cnt0_o), .pkt_cnt1_o(pkt_cnt1_o),
        .pkt_cnt2_o(pkt_cnt2_o), .err_o(err_o), .err_code_o(err_code_o), .err_clr_i(err_clr_i)
    );

    typedef struct packed {
        logic [1:0]  chid;
        logic        last;
        logic [31:0] data;
    } word_t;

    word_t       q[$];
    int unsigned m_cnt [3];
    logic        m_err;
    logic [2:0]  m_code;
    bit          pst [64];
    bit          pen [64];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;
    int          rdy_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output stream must be exactly the committed words, in order, no earlier.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_vld", out_vld_o, q.size() != 0);
            if (out_vld_o && q.size() != 0) begin
                chk("out_word", {out_chid_o, out_last_o, out_data_o}, q[0]);
                if (out_rdy_i) void'(q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_rdy_i = 1'b0;
            1:       out_rdy_i = 1'b1;
            default: out_rdy_i = 1'($urandom % 2);
        endcase
    end

    // Packet outcome from the framing rules: error code (0 = commit) and words consumed.
    function automatic void eval(input int len, input logic [1:0] chid, output int code, output int nw);
        code = 0;
        nw = len;
        for (int k = 0; k < len; k++) begin
            if (pen[k] && k < len - 1) begin code = 1; nw = k + 1; return; end
            if (pst[k] && k > 0)       begin code = 4; nw = k + 1; return; end
            if (k == len - 1) begin
                code = !pen[k] ? 2 : (chid == 2'd3) ? 5 : 0;
                return;
            end
        end
    endfunction

    // Grant is expected exactly when the free space seen at the deciding edge covers len.
    task automatic request(input logic [1:0] chid, input int len, input int release_at, output int lat);
        int f_prev;
        bit got;
        fmt_req_i = 1'b1;
        fmt_chid_i = chid;
        fmt_length_i = 6'(len);
        f_prev = DEPTH - q.size();
        lat = 0;
        got = 1'b0;
        while (!got && lat < 3000) begin
            step();
            lat++;
            if (lat == release_at) rdy_mode = 1;
            chk("grant", fmt_grant_o, f_prev >= len);
            got = fmt_grant_o;
            f_prev = DEPTH - q.size();
        end
        fmt_req_i = 1'b0;
        if (!got) begin
            n_fail++;
            $display("FAIL grant_timeout: no grant for len %0d", len);
        end
    endtask

    task automatic idle_inputs();
        fmt_start_i = 1'b0;
        fmt_end_i = 1'b0;
        fmt_data_i = 32'd0;
    endtask

    task automatic check_state();
        chk("err", err_o, m_err);
        chk("err_code", err_code_o, m_code);
        chk("pkt_cnt0", pkt_cnt0_o, CW'(m_cnt[0]));
        chk("pkt_cnt1", pkt_cnt1_o, CW'(m_cnt[1]));
        chk("pkt_cnt2", pkt_cnt2_o, CW'(m_cnt[2]));
    endtask

    // kind: 0 good, 1 early end at pos, 2 restart at pos, 3 missing end, 5 timeout (pos=1: clear on error cycle)
    task automatic send_pkt(input logic [1:0] chid, input int len, input int kind, input int d,
                            input int pos, input logic [31:0] base, input int release_at, output int lat);
        int code, nw;
        for (int k = 0; k < 64; k++) begin pst[k] = 1'b0; pen[k] = 1'b0; end
        pst[0] = 1'b1;
        pen[len-1] = 1'b1;
        case (kind)
            1: begin pen[len-1] = 1'b0; pen[pos] = 1'b1; end
            2: pst[pos] = 1'b1;
            3: pen[len-1] = 1'b0;
            default: ;
        endcase
        request(chid, len, release_at, lat);
        if (kind == 5) begin
            for (int i = 0; i < int'(START_TO); i++) begin
                step();
                fmt_start_i = 1'b0;
                fmt_end_i = 1'($urandom % 2);
                if (i == int'(START_TO) - 1 && pos == 1) err_clr_i = 1'b1;
            end
            code = 3;
            nw = 0;
        end else begin
            eval(len, chid, code, nw);
            for (int i = 0; i < d; i++) begin
                step();
                fmt_start_i = 1'b0;
                fmt_end_i = 1'($urandom % 2);
            end
            for (int k = 0; k < nw; k++) begin
                step();
                fmt_start_i = pst[k];
                fmt_end_i = pen[k];
                fmt_data_i = base + 32'(k);
            end
        end
        step();
        idle_inputs();
        err_clr_i = 1'b0;
        if (code == 0) begin
            for (int k = 0; k < len; k++) q.push_back({chid, k == len - 1, base + 32'(k)});
            m_cnt[chid]++;
        end else begin
            m_err = 1'b1;
            m_code = 3'(code);
        end
        check_state();
    endtask

    task automatic drain();
        rdy_mode = 1;
        for (int i = 0; i < 500 && q.size() != 0; i++) step();
        step();
        chk("drained_vld", out_vld_o, 1'b0);
    endtask

    initial begin
        int lat, len, kind, pos;
        logic [1:0] chid;
        rst_i = 1'b1; fmt_req_i = 1'b0; fmt_chid_i = 2'd0; fmt_length_i = 6'd0;
        err_clr_i = 1'b0; out_rdy_i = 1'b0;
        idle_inputs();
        m_cnt = '{0, 0, 0}; m_err = 1'b0; m_code = 3'd0;
        repeat (3) step();
        rst_i = 1'b0;
        chk_en = 1'b1;
        chk("rst_vld", out_vld_o, 1'b0);
        chk("rst_grant", fmt_grant_o, 1'b0);
        chk("rst_data", out_data_o, 32'd0);
        check_state();

        // First packet, output stalled so the head word can be pinned.
        send_pkt(2'd1, 8, 0, 0, 0, 32'h100, -1, lat);
        chk("lat_first", lat, 1);
        chk("head_vld", out_vld_o, 1'b1);
        chk("head_data", out_data_o, 32'h100);
        chk("head_chid", out_chid_o, 2'd1);
        chk("head_last", out_last_o, 1'b0);
        chk("cnt1_first", pkt_cnt1_o, 16'd1);
        drain();

        // Fill to 56 words with output stalled; a len-16 request must wait for reads.
        rdy_mode = 0;
        step();
        for (int i = 0; i < 7; i++) send_pkt(2'(i % 3), 8, 0, 0, 0, 32'h1000 * (i + 1), -1, lat);
        send_pkt(2'd0, 16, 0, 1, 0, 32'h8000, 10, lat);
        chk("fill_blocked", lat > 10, 1'b1);

        rdy_mode = 2;
        send_pkt(2'd0, 8, 1, 0, 3, 32'h200, -1, lat);
        chk("early_end_code", err_code_o, 3'd1);
        send_pkt(2'd1, 8, 0, 2, 0, 32'h300, -1, lat);
        send_pkt(2'd2, 4, 3, 0, 0, 32'h400, -1, lat);
        chk("missing_end_code", err_code_o, 3'd2);
        send_pkt(2'd0, 4, 5, 0, 1, 32'h500, -1, lat);
        chk("timeout_code", err_code_o, 3'd3);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        m_err = 1'b0;
        m_code = 3'd0;
        chk("clr_err", err_o, 1'b0);
        chk("clr_code", err_code_o, 3'd0);
        send_pkt(2'd3, 4, 0, 0, 0, 32'h600, -1, lat);
        chk("bad_chid_code", err_code_o, 3'd5);
        send_pkt(2'd2, 1, 0, 0, 0, 32'h700, -1, lat);
        send_pkt(2'd1, 5, 0, int'(START_TO) - 1, 0, 32'h800, -1, lat);
        send_pkt(2'd0, 6, 2, 1, 4, 32'h900, -1, lat);
        chk("restart_code", err_code_o, 3'd4);

        for (int n = 0; n < 150; n++) begin
            chid = 2'($urandom % 4);
            len = ($urandom % 4 == 0) ? 1 + int'($urandom % 40) : 1 + int'($urandom % 12);
            kind = int'($urandom % 8);
            kind = (kind < 3) ? 0 : (kind == 6) ? 0 : (kind == 7) ? 5 : kind - 2;
            if (len == 1 && kind != 5) kind = 0;
            pos = 0;
            if (kind == 1) pos = int'($urandom % (len - 1));
            if (kind == 2) pos = 1 + int'($urandom % (len - 1));
            if (kind == 5) pos = int'($urandom % 2);
            send_pkt(chid, len, kind, int'($urandom % START_TO), pos, $urandom, -1, lat);
            if ($urandom % 10 == 0) begin
                err_clr_i = 1'b1;
                step();
                err_clr_i = 1'b0;
                m_err = 1'b0;
                m_code = 3'd0;
                check_state();
            end
        end
        drain();

        // Reset mid-packet with committed words pending.
        rdy_mode = 0;
        step();
        send_pkt(2'd0, 4, 0, 0, 0, 32'hA00, -1, lat);
        send_pkt(2'd1, 4, 0, 0, 0, 32'hB00, -1, lat);
        request(2'd2, 16, -1, lat);
        for (int k = 0; k < 6; k++) begin
            step();
            fmt_start_i = (k == 0);
            fmt_end_i = 1'b0;
            fmt_data_i = 32'hC00 + 32'(k);
            if (k == 5) rst_i = 1'b1;
        end
        step();
        rst_i = 1'b0;
        idle_inputs();
        q.delete();
        m_cnt = '{0, 0, 0};
        m_err = 1'b0;
        m_code = 3'd0;
        chk("rst2_vld", out_vld_o, 1'b0);
        chk("rst2_data", out_data_o, 32'd0);
        chk("rst2_chid", out_chid_o, 2'd0);
        chk("rst2_last", out_last_o, 1'b0);
        chk("rst2_grant", fmt_grant_o, 1'b0);
        check_state();
        send_pkt(2'd2, 3, 0, 0, 0, 32'hD00, -1, lat);
        chk("post_rst_lat", lat, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fmt_sink.md
Name: fmt_sink

Overview:
- Downstream consumer of the MCDF formatter interface (fmt_req/fmt_grant/fmt_chid/fmt_length/fmt_data/fmt_start/fmt_end).
- Grants a packet only when its buffer can hold the announced length, then captures and checks the packet framing.
- Commits good packets to a FIFO and drops bad ones atomically; committed packets go out on a valid/ready stream with per-word channel id and a last flag.
- Keeps per-channel packet counters and a sticky error code, for use as a board-level sink and a reusable checker stage.

Parameters:
- DEPTH, 64, buffer depth in words; power of two, >= 32.
- START_TO, 4, maximum cycles from grant to fmt_start_i before a timeout error.
- CNT_WIDTH, 16, width of the per-channel packet counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- fmt_req_i  in  1  formatter packet request
- fmt_chid_i  in  2  packet channel id
- fmt_length_i  in  6  packet length in words
- fmt_data_i  in  32  packet data
- fmt_start_i  in  1  first-word marker
- fmt_end_i  in  1  last-word marker
- fmt_grant_o  out  1  one-cycle grant
- out_vld_o  out  1  output word valid
- out_rdy_i  in  1  output word accepted
- out_data_o  out  32  output data
- out_chid_o  out  2  channel id of the output word
- out_last_o  out  1  last word of the packet
- pkt_cnt0_o / pkt_cnt1_o / pkt_cnt2_o  out  CNT_WIDTH each  committed packets per channel
- err_o  out  1  sticky error flag
- err_code_o  out  3  most recent error code
- err_clr_i  in  1  clears err_o and err_code_o

Behaviour:
- Reset: synchronous, active-high. It aborts any packet in progress, so no partial commit occurs. All outputs go to 0, pointers clear, FSM goes to IDLE.
- Buffer: each entry holds {chid, last, data}, 35 bits. Pointers are rd_ptr, wr_ptr (speculative) and cm_ptr (committed).
- Space: used = wr_ptr - rd_ptr, with one extra pointer bit. free = DEPTH - used.
- FSM states: IDLE, GRANT, WAIT_START, RECV.
- IDLE: when fmt_req_i = 1 and free >= fmt_length_i:
  - latch chid and length;
  - set hdr_bad if chid = 3 or length = 0;
  - go to GRANT.
  - Otherwise stay in IDLE; fmt_req_i is never granted while space is short.
- GRANT: fmt_grant_o = 1 for exactly this one cycle, then go to WAIT_START with the timeout counter cleared.
- WAIT_START:
  - On fmt_start_i = 1, that cycle's word is word 0; go to RECV and apply the word rules below.
  - If START_TO cycles pass with no start, record error 3 and go to IDLE.
  - fmt_end_i without fmt_start_i is ignored here.
- RECV: every cycle is one word and is written at wr_ptr, which then increments. Word index k runs 0..len-1. Each cycle takes the first matching rule:
  - fmt_end_i = 1 and k < len-1: error 1 (early end). Roll back wr_ptr to cm_ptr and go to IDLE.
  - fmt_start_i = 1 and k > 0: error 4 (restart). Roll back and go to IDLE.
  - k = len-1 and fmt_end_i = 0: error 2 (missing end). Roll back and go to IDLE.
  - k = len-1 and fmt_end_i = 1:
    - if hdr_bad: error 5, roll back;
    - else write the word with last = 1, set cm_ptr = wr_ptr+1, increment pkt_cnt[chid] (wraps), go to IDLE.
- Single-word packets (len = 1) need fmt_start_i and fmt_end_i in the same cycle.
- fmt_grant_o is never asserted outside GRANT, so grants cannot overlap.
- Output side:
  - out_vld_o = (rd_ptr != cm_ptr). out_data_o, out_chid_o and out_last_o come from entry rd_ptr.
  - rd_ptr increments when out_vld_o && out_rdy_i.
  - Uncommitted words are never visible.
  - The first word becomes visible the cycle after the fmt_end_i cycle.
- A simultaneous read and commit in the same cycle is legal; both pointers update.
- Rollback with pending reads does not disturb rd_ptr.
- Errors:
  - On an error event, err_o <= 1 and err_code_o <= code.
  - err_clr_i clears both, but an error event in the same cycle wins.
  - A later error overwrites the code.
- Pointer wrap-around is modulo DEPTH. The full condition uses the extra pointer bit.

Test Plan:
- Reset, then request chid 1, len 8 with a well-formed packet of data 0x100..0x107 → grant pulse 1 cycle after request; out stream shows 8 words, chid 1, last on 0x107; pkt_cnt1_o = 1.
- Fill the buffer with 7 committed len-8 packets while out_rdy_i = 0, then request len 16 → no grant (free = 8). Raise out_rdy_i → grant once free >= 16.
- len 8 with fmt_end_i at word 3 → err_code_o = 1, err_o = 1, nothing output, counters unchanged. Next good packet is output intact.
- len 4 with no fmt_end_i on word 3 → err_code_o = 2. Grant, then no fmt_start_i for START_TO = 4 cycles → err_code_o = 3, FSM back to IDLE. Assert err_clr_i → err_o = 0.
- chid 3, len 4, well-formed → err_code_o = 5, no output. Then len 1 with start+end together on chid 2 → a single word with last = 1; pkt_cnt2_o increments.
- Assert rst_i at word 5 of a len-16 packet with 2 committed packets pending → all outputs 0, out_vld_o = 0, counters 0, and the FSM grants a new request normally after reset.
